iommu_walker_arbiter: RTL and testbench
=======================================

Name: iommu_walker_arbiter

Overview:
Shares a single AXI4 read master port toward memory between the two page-table walker ports: s0 from the read-channel translator and s1 from the write-channel translator.
Arbitration is round-robin, with one outstanding transaction at a time. The grant is held from AR acceptance until the final R beat.
The block sits between the two iommu_address_translator walker ports and the memory interconnect. It also exposes a hold input so that table walks can be frozen during flush or reconfiguration.

Parameters:
ADDR_W, 34, walker AXI address width
DATA_W, 256, walker AXI data width
ID_W, 3, AXI ID width; IDs pass through unchanged
CNT_W, 16, width of the per-port grant counters

Ports:
clk  input  1  single clock
reset  input  1  synchronous, active-high reset
hold  input  1  when 1, no new grant is issued; an in-flight transaction completes
s{0,1}_axi_araddr  input  ADDR_W  walker read address
s{0,1}_axi_arlen/arsize/arburst  input  8/3/2  burst attributes
s{0,1}_axi_arlock/arcache/arprot  input  1/4/3  access attributes
s{0,1}_axi_arid  input  ID_W  transaction ID
s{0,1}_axi_arvalid  input  1  request valid
s{0,1}_axi_arready  output  1  request accepted
s{0,1}_axi_rdata/rresp/rid  output  DATA_W/2/ID_W  routed read data
s{0,1}_axi_rlast/rvalid  output  1/1  routed beat control
s{0,1}_axi_rready  input  1  walker ready for data
m_axi_ar{addr,len,size,burst,lock,cache,prot,id}  output  as s side  registered AR fields
m_axi_arvalid  output  1  AR valid to memory
m_axi_arready  input  1  memory accepts AR
m_axi_r{data,resp,id,last,valid}  input  as s side  read data from memory
m_axi_rready  output  1  ready toward memory
busy  output  1  1 whenever state != IDLE
grant_idx  output  1  index of the port currently or last granted
dbg_grant_cnt0/1  output  CNT_W  number of grants to each port, saturating

Behaviour:
- Reset values:
  - state is IDLE.
  - All arready, arvalid, rvalid and rready outputs are 0.
  - AR field registers are 0.
  - The priority pointer favours s0.
  - grant_idx = 0, busy = 0, counters = 0.
- IDLE:
  - If hold = 1, no grant is issued.
  - If only one port has arvalid = 1, that port is granted.
  - If both have arvalid = 1, the port not granted last is granted. After reset, s0 wins.
  - At the granting edge: the winner's AR fields are latched into the m_axi_ar* registers, grant_idx is set, and the state moves to ADDR.
- ADDR:
  - m_axi_arvalid = 1 and the granted s*_axi_arready = 1, both for the first ADDR cycle only.
  - The s-side AR handshake therefore completes one cycle after grant. AXI requires the walker to hold arvalid, so this is safe.
  - m_axi_arvalid then stays 1 with stable fields until m_axi_arready = 1. On that handshake the state moves to RESP.
  - Minimum latency: s arvalid at edge N gives m arvalid high during cycle N+1.
- RESP:
  - m_axi_r* is routed combinationally to the granted port: rvalid = m_rvalid, and m_axi_rready = granted port's rready.
  - The non-granted port sees rvalid = 0; all its other r outputs are don't-care and are driven 0.
  - On m_rvalid & m_rready & m_rlast: return to IDLE, flip the priority pointer to favour the other port, and increment the granted port's counter, saturating at all-ones.
- While busy, the non-granted port's arready = 0. Its request waits and is served in the very next IDLE cycle after rlast.
- No bypass: one dead IDLE cycle separates transactions.
- m_axi_rready is 0 in IDLE and ADDR. Beats arriving there are held by the interconnect.
- hold asserted mid-transaction has no effect until the return to IDLE.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. The outstanding burst is abandoned; system reset is global.
- rresp is passed through untouched. Error handling belongs to the translator.

Decomposition:
- Package iommu_walker_pkg:
  - state encoding (IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2);
  - AXI width constants ADDR_W / DATA_W / ID_W, shared with iommu_address_translator.
- One natural sub-module: iommu_rr_arb2. It is the 2-way round-robin pick plus priority pointer, taking req[1:0], a hold input and an update strobe, and returning grant_idx and a grant_valid output.

Test Plan:
- s0 alone requests araddr=0x0_1000_0000, arlen=0, arid=2 → m_arvalid in cycle +1 with identical fields; m_arready at +3; one beat with rlast → s0 sees rdata and rid=2; dbg_grant_cnt0 = 1; state returns to IDLE.
- Both request simultaneously after reset → s0 granted first, then s1 in the IDLE cycle after s0's rlast; a third simultaneous pair → s0 again.
- s1 burst arlen=3 while s0 waits; s1 rready toggles 1,0,1,1,0,1 → m_rready mirrors the toggling; exactly 4 beats delivered to s1; s0 arready stays 0 until s1's last beat.
- hold=1 with s0 arvalid held for 10 cycles → no m_arvalid; hold released → m_arvalid on the second cycle after release.
- reset asserted during RESP beat 2 of a 4-beat burst → next cycle all valids and readies are 0, busy = 0; counters reset to 0.
- 65,540 back-to-back s0 grants → dbg_grant_cnt0 saturates at 0xFFFF.

Source files
------------

// File: rtl/iommu_walker_pkg.sv
// Shared definitions for the IOMMU page-table walker datapath: AXI widths and
// the walker-arbiter state encoding.
package iommu_walker_pkg;

  localparam int ADDR_W = 34;
  localparam int DATA_W = 256;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/iommu_rr_arb2.sv
// Two-way round-robin pick; combinational grant, pointer updated on completion.
// Pointer 0 favours requester 0; after an update it favours the port not just served.
module iommu_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       hold,
  input  logic       update,
  input  logic       update_idx,
  output logic       grant_idx,
  output logic       grant_valid
);

  logic prio_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (update) begin
      prio_q <= ~update_idx;
    end
  end

  always_comb begin
    grant_valid = (|req) && !hold;
    grant_idx   = (req == 2'b11) ? prio_q : req[1];
  end

endmodule

// File: rtl/iommu_walker_arbiter.sv
// Shares one AXI read master between two walker ports, one transaction at a time.
// AR reaches memory one cycle after grant; R beats are routed combinationally with rready passed back.
module iommu_walker_arbiter #(
  parameter int ADDR_W = iommu_walker_pkg::ADDR_W,
  parameter int DATA_W = iommu_walker_pkg::DATA_W,
  parameter int ID_W   = iommu_walker_pkg::ID_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [ADDR_W-1:0] s0_axi_araddr,
  input  logic [7:0]        s0_axi_arlen,
  input  logic [2:0]        s0_axi_arsize,
  input  logic [1:0]        s0_axi_arburst,
  input  logic              s0_axi_arlock,
  input  logic [3:0]        s0_axi_arcache,
  input  logic [2:0]        s0_axi_arprot,
  input  logic [ID_W-1:0]   s0_axi_arid,
  input  logic              s0_axi_arvalid,
  output logic              s0_axi_arready,
  output logic [DATA_W-1:0] s0_axi_rdata,
  output logic [1:0]        s0_axi_rresp,
  output logic [ID_W-1:0]   s0_axi_rid,
  output logic              s0_axi_rlast,
  output logic              s0_axi_rvalid,
  input  logic              s0_axi_rready,
  input  logic [ADDR_W-1:0] s1_axi_araddr,
  input  logic [7:0]        s1_axi_arlen,
  input  logic [2:0]        s1_axi_arsize,
  input  logic [1:0]        s1_axi_arburst,
  input  logic              s1_axi_arlock,
  input  logic [3:0]        s1_axi_arcache,
  input  logic [2:0]        s1_axi_arprot,
  input  logic [ID_W-1:0]   s1_axi_arid,
  input  logic              s1_axi_arvalid,
  output logic              s1_axi_arready,
  output logic [DATA_W-1:0] s1_axi_rdata,
  output logic [1:0]        s1_axi_rresp,
  output logic [ID_W-1:0]   s1_axi_rid,
  output logic              s1_axi_rlast,
  output logic              s1_axi_rvalid,
  input  logic              s1_axi_rready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              busy,
  output logic              grant_idx,
  output logic [CNT_W-1:0]  dbg_grant_cnt0,
  output logic [CNT_W-1:0]  dbg_grant_cnt1
);
  import iommu_walker_pkg::*;

  state_t state_q, state_d;
  logic   gnt_q;
  logic   addr_first_q;
  logic   arb_idx, arb_vld;
  logic   grant, done;

  iommu_rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({s1_axi_arvalid, s0_axi_arvalid}),
    .hold        (hold),
    .update      (done),
    .update_idx  (gnt_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_vld)
  );

  assign grant = (state_q == IDLE) && arb_vld;
  assign done  = (state_q == RESP) && m_axi_rvalid && m_axi_rready && m_axi_rlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ADDR;
      ADDR:    if (m_axi_arready) state_d = RESP;
      RESP:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // AR fields are captured at grant so memory sees them stable however long arready stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q          <= 1'b0;
      addr_first_q   <= 1'b0;
      m_axi_araddr   <= '0;
      m_axi_arlen    <= '0;
      m_axi_arsize   <= '0;
      m_axi_arburst  <= '0;
      m_axi_arlock   <= 1'b0;
      m_axi_arcache  <= '0;
      m_axi_arprot   <= '0;
      m_axi_arid     <= '0;
      dbg_grant_cnt0 <= '0;
      dbg_grant_cnt1 <= '0;
    end else begin
      addr_first_q <= grant;
      if (grant) begin
        gnt_q         <= arb_idx;
        m_axi_araddr  <= arb_idx ? s1_axi_araddr  : s0_axi_araddr;
        m_axi_arlen   <= arb_idx ? s1_axi_arlen   : s0_axi_arlen;
        m_axi_arsize  <= arb_idx ? s1_axi_arsize  : s0_axi_arsize;
        m_axi_arburst <= arb_idx ? s1_axi_arburst : s0_axi_arburst;
        m_axi_arlock  <= arb_idx ? s1_axi_arlock  : s0_axi_arlock;
        m_axi_arcache <= arb_idx ? s1_axi_arcache : s0_axi_arcache;
        m_axi_arprot  <= arb_idx ? s1_axi_arprot  : s0_axi_arprot;
        m_axi_arid    <= arb_idx ? s1_axi_arid    : s0_axi_arid;
      end
      if (done && !gnt_q && (dbg_grant_cnt0 != '1)) dbg_grant_cnt0 <= dbg_grant_cnt0 + CNT_W'(1);
      if (done &&  gnt_q && (dbg_grant_cnt1 != '1)) dbg_grant_cnt1 <= dbg_grant_cnt1 + CNT_W'(1);
    end
  end

  assign busy           = (state_q != IDLE);
  assign grant_idx      = gnt_q;
  assign m_axi_arvalid  = (state_q == ADDR);
  assign s0_axi_arready = (state_q == ADDR) && addr_first_q && !gnt_q;
  assign s1_axi_arready = (state_q == ADDR) && addr_first_q &&  gnt_q;

  always_comb begin
    s0_axi_rdata  = '0;
    s0_axi_rresp  = '0;
    s0_axi_rid    = '0;
    s0_axi_rlast  = 1'b0;
    s0_axi_rvalid = 1'b0;
    s1_axi_rdata  = '0;
    s1_axi_rresp  = '0;
    s1_axi_rid    = '0;
    s1_axi_rlast  = 1'b0;
    s1_axi_rvalid = 1'b0;
    m_axi_rready  = 1'b0;
    if (state_q == RESP) begin
      if (gnt_q) begin
        s1_axi_rdata  = m_axi_rdata;
        s1_axi_rresp  = m_axi_rresp;
        s1_axi_rid    = m_axi_rid;
        s1_axi_rlast  = m_axi_rlast;
        s1_axi_rvalid = m_axi_rvalid;
        m_axi_rready  = s1_axi_rready;
      end else begin
        s0_axi_rdata  = m_axi_rdata;
        s0_axi_rresp  = m_axi_rresp;
        s0_axi_rid    = m_axi_rid;
        s0_axi_rlast  = m_axi_rlast;
        s0_axi_rvalid = m_axi_rvalid;
        m_axi_rready  = s0_axi_rready;
      end
    end
  end

endmodule

// File: tb/tb_iommu_walker_arbiter.sv
// Directed bench for the walker arbiter: a vector table of request rounds plus
// hand-written reset, hold and counter-saturation sequences.
module tb_iommu_walker_arbiter;

  localparam int AW = 34;
  localparam int DW = 256;
  localparam int IW = 3;
  localparam int CW = 5;

  logic clk, reset, hold;
  logic [AW-1:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
  logic [7:0]    s0_axi_arlen, s1_axi_arlen, m_axi_arlen;
  logic [2:0]    s0_axi_arsize, s1_axi_arsize, m_axi_arsize;
  logic [1:0]    s0_axi_arburst, s1_axi_arburst, m_axi_arburst;
  logic          s0_axi_arlock, s1_axi_arlock, m_axi_arlock;
  logic [3:0]    s0_axi_arcache, s1_axi_arcache, m_axi_arcache;
  logic [2:0]    s0_axi_arprot, s1_axi_arprot, m_axi_arprot;
  logic [IW-1:0] s0_axi_arid, s1_axi_arid, m_axi_arid;
  logic          s0_axi_arvalid, s1_axi_arvalid, m_axi_arvalid;
  logic          s0_axi_arready, s1_axi_arready, m_axi_arready;
  logic [DW-1:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
  logic [1:0]    s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
  logic [IW-1:0] s0_axi_rid, s1_axi_rid, m_axi_rid;
  logic          s0_axi_rlast, s1_axi_rlast, m_axi_rlast;
  logic          s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
  logic          s0_axi_rready, s1_axi_rready, m_axi_rready;
  logic          busy, grant_idx;
  logic [CW-1:0] dbg_grant_cnt0, dbg_grant_cnt1;

  iommu_walker_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen), .s0_axi_arsize(s0_axi_arsize),
    .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock), .s0_axi_arcache(s0_axi_arcache),
    .s0_axi_arprot(s0_axi_arprot), .s0_axi_arid(s0_axi_arid), .s0_axi_arvalid(s0_axi_arvalid),
    .s0_axi_arready(s0_axi_arready), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid),
    .s0_axi_rready(s0_axi_rready),
    .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen), .s1_axi_arsize(s1_axi_arsize),
    .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock), .s1_axi_arcache(s1_axi_arcache),
    .s1_axi_arprot(s1_axi_arprot), .s1_axi_arid(s1_axi_arid), .s1_axi_arvalid(s1_axi_arvalid),
    .s1_axi_arready(s1_axi_arready), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid),
    .s1_axi_rready(s1_axi_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .busy(busy), .grant_idx(grant_idx),
    .dbg_grant_cnt0(dbg_grant_cnt0), .dbg_grant_cnt1(dbg_grant_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] pa [2];
  logic [7:0]    pl [2];
  logic [IW-1:0] pi [2];

  typedef struct {
    bit            rst;
    logic [1:0]    set;
    logic [AW-1:0] a0, a1;
    logic [7:0]    l0, l1;
    logic [IW-1:0] i0, i1;
    int            exp;
    int            dly;
    logic [7:0]    rr;
    int            c0, c1;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_dat(input int p, input int b);
    return {8{32'hA500_0000 + 32'(p * 256 + b)}};
  endfunction

  function automatic logic [12:0] attr_exp(input int p);
    return (p != 0) ? {3'd4, 2'd2, 1'b1, 4'hF, 3'd6} : {3'd5, 2'd1, 1'b0, 4'h2, 3'd1};
  endfunction

  function automatic logic arready_of(input int p);
    return (p != 0) ? s1_axi_arready : s0_axi_arready;
  endfunction

  function automatic logic rvalid_of(input int p);
    return (p != 0) ? s1_axi_rvalid : s0_axi_rvalid;
  endfunction

  task automatic set_arvalid(input int p, input logic v);
    if (p != 0) s1_axi_arvalid = v; else s0_axi_arvalid = v;
  endtask

  task automatic set_rready(input int p, input logic v);
    if (p != 0) s1_axi_rready = v; else s0_axi_rready = v;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id);
    pa[p] = a; pl[p] = l; pi[p] = id;
    if (p != 0) begin
      s1_axi_araddr = a; s1_axi_arlen = l; s1_axi_arid = id;
    end else begin
      s0_axi_araddr = a; s0_axi_arlen = l; s0_axi_arid = id;
    end
    set_arvalid(p, 1'b1);
  endtask

  task automatic chk_ar(input int p);
    chk("m_araddr", 64'(m_axi_araddr), 64'(pa[p]));
    chk("m_arlen", 64'(m_axi_arlen), 64'(pl[p]));
    chk("m_arid", 64'(m_axi_arid), 64'(pi[p]));
    chk("m_arattr", 64'({m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot}),
        64'(attr_exp(p)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; hold = 1'b0;
    s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0;
    s0_axi_rready = 1'b0; s1_axi_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_m_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("rst_arready", 64'({s1_axi_arready, s0_axi_arready}), 64'(0));
    chk("rst_rvalid", 64'({s1_axi_rvalid, s0_axi_rvalid}), 64'(0));
    chk("rst_m_rready", 64'(m_axi_rready), 64'(0));
    chk("rst_grant_idx", 64'(grant_idx), 64'(0));
    chk("rst_cnt", 64'({dbg_grant_cnt1, dbg_grant_cnt0}), 64'(0));
    chk("rst_m_ar", 64'({m_axi_araddr, m_axi_arid}), 64'(0));
    reset = 1'b0;
  endtask

  // One complete transaction for port p, starting from an already-pending request.
  task automatic run_txn(input int p, input int dly, input logic [7:0] rr, input int c0, input int c1);
    int w, b, c;
    logic got;
    w = 0; got = 1'b0;
    while (!got && w < 20) begin
      @(negedge clk); #1;
      w++;
      got = m_axi_arvalid;
    end
    if (!got) begin
      chk("ar_timeout", 64'(0), 64'(1));
      return;
    end
    chk("ar_latency", 64'(w), 64'(1));
    chk("grant_idx", 64'(grant_idx), 64'(p));
    chk("s_arready_first", 64'(arready_of(p)), 64'(1));
    chk("s_arready_other", 64'(arready_of(1 - p)), 64'(0));
    chk_ar(p);
    for (int d = 0; d <= dly; d++) begin
      @(negedge clk);
      set_arvalid(p, 1'b0);
      m_axi_arready = (d == dly);
      #1;
      chk("m_arvalid_held", 64'(m_axi_arvalid), 64'(1));
      chk("s_arready_once", 64'(arready_of(p)), 64'(0));
      chk("s_arready_other", 64'(arready_of(1 - p)), 64'(0));
      chk("m_rready_addr", 64'(m_axi_rready), 64'(0));
      chk_ar(p);
    end
    b = 0; c = 0;
    while (b <= int'(pl[p]) && c < 40) begin
      @(negedge clk);
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b1;
      m_axi_rdata   = beat_dat(p, b);
      m_axi_rresp   = 2'(b);
      m_axi_rid     = pi[p];
      m_axi_rlast   = (b == int'(pl[p]));
      set_rready(p, rr[c % 8]);
      set_rready(1 - p, 1'b1);
      #1;
      chk("m_rready_mirror", 64'(m_axi_rready), 64'(rr[c % 8]));
      chk("s_rvalid_granted", 64'(rvalid_of(p)), 64'(1));
      chk("s_rvalid_other", 64'(rvalid_of(1 - p)), 64'(0));
      chk("s_arready_other_resp", 64'(arready_of(1 - p)), 64'(0));
      if (rr[c % 8]) begin
        if (p != 0) begin
          chkw("s1_rdata", s1_axi_rdata, beat_dat(p, b));
          chk("s1_r_ctl", 64'({s1_axi_rid, s1_axi_rresp, s1_axi_rlast}),
              64'({pi[p], 2'(b), (b == int'(pl[p]))}));
          chkw("s0_rdata_zero", s0_axi_rdata, '0);
        end else begin
          chkw("s0_rdata", s0_axi_rdata, beat_dat(p, b));
          chk("s0_r_ctl", 64'({s0_axi_rid, s0_axi_rresp, s0_axi_rlast}),
              64'({pi[p], 2'(b), (b == int'(pl[p]))}));
          chkw("s1_rdata_zero", s1_axi_rdata, '0);
        end
        b++;
      end
      c++;
    end
    if (c >= 40) chk("r_timeout", 64'(0), 64'(1));
    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    #1;
    chk("idle_after_rlast", 64'(busy), 64'(0));
    chk("m_rready_idle", 64'(m_axi_rready), 64'(0));
    chk("cnt0", 64'(dbg_grant_cnt0), 64'(c0));
    chk("cnt1", 64'(dbg_grant_cnt1), 64'(c1));
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    s0_axi_araddr = '0; s0_axi_arlen = '0; s0_axi_arid = '0; s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b0;
    s1_axi_araddr = '0; s1_axi_arlen = '0; s1_axi_arid = '0; s1_axi_arvalid = 1'b0; s1_axi_rready = 1'b0;
    s0_axi_arsize = 3'd5; s0_axi_arburst = 2'd1; s0_axi_arlock = 1'b0; s0_axi_arcache = 4'h2; s0_axi_arprot = 3'd1;
    s1_axi_arsize = 3'd4; s1_axi_arburst = 2'd2; s1_axi_arlock = 1'b1; s1_axi_arcache = 4'hF; s1_axi_arprot = 3'd6;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rid = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

    //           rst  set    a0               a1               l0    l1    i0    i1    exp dly rr      c0 c1
    vt[0] = '{1'b1, 2'b01, 34'h0_1000_0000, 34'h0,           8'd0, 8'd0, 3'd2, 3'd0, 0,  1,  8'hFF,  1, 0};
    vt[1] = '{1'b1, 2'b11, 34'h0_2000_0040, 34'h3_0000_0080, 8'd0, 8'd1, 3'd1, 3'd5, 0,  0,  8'hFF,  1, 0};
    vt[2] = '{1'b0, 2'b00, 34'h0,           34'h0,           8'd0, 8'd0, 3'd0, 3'd0, 1,  0,  8'hFF,  1, 1};
    vt[3] = '{1'b0, 2'b11, 34'h1_0000_1000, 34'h2_ABCD_0000, 8'd0, 8'd3, 3'd3, 3'd7, 0,  1,  8'hFF,  2, 1};
    vt[4] = '{1'b0, 2'b01, 34'h0_0BAD_F000, 34'h0,           8'd2, 8'd0, 3'd4, 3'd0, 1,  2,  8'hED,  2, 2};
    vt[5] = '{1'b0, 2'b00, 34'h0,           34'h0,           8'd0, 8'd0, 3'd0, 3'd0, 0,  0,  8'hFA,  3, 2};
    vt[6] = '{1'b0, 2'b10, 34'h0,           34'h3_FFFF_FFC0, 8'd0, 8'd0, 3'd0, 3'd1, 1,  3,  8'hFF,  3, 3};

    for (int i = 0; i < 7; i++) begin
      if (vt[i].rst) do_reset();
      if (vt[i].set[0]) set_req(0, vt[i].a0, vt[i].l0, vt[i].i0);
      if (vt[i].set[1]) set_req(1, vt[i].a1, vt[i].l1, vt[i].i1);
      run_txn(vt[i].exp, vt[i].dly, vt[i].rr, vt[i].c0, vt[i].c1);
    end

    // Reset while beat 2 of a 4-beat burst is on the bus.
    set_req(0, 34'h1_2345_6780, 8'd3, 3'd6);
    @(negedge clk); #1;
    chk("rstmid_arvalid", 64'(m_axi_arvalid), 64'(1));
    @(negedge clk); s0_axi_arvalid = 1'b0; m_axi_arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0;
      m_axi_rdata = beat_dat(0, k); s0_axi_rready = 1'b1;
      if (k == 2) reset = 1'b1;
      #1;
      chk("rstmid_rvalid", 64'(s0_axi_rvalid), 64'(1));
    end
    @(negedge clk); reset = 1'b0; #1;
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_valids", 64'({m_axi_arvalid, s0_axi_rvalid, s1_axi_rvalid}), 64'(0));
    chk("rstmid_readies", 64'({m_axi_rready, s0_axi_arready, s1_axi_arready}), 64'(0));
    chk("rstmid_cnt", 64'({dbg_grant_cnt1, dbg_grant_cnt0}), 64'(0));
    chk("rstmid_grant_idx", 64'(grant_idx), 64'(0));
    m_axi_rvalid = 1'b0;

    // hold freezes granting while a request waits.
    @(negedge clk);
    hold = 1'b1;
    set_req(0, 34'h0_0000_2000, 8'd0, 3'd5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("hold_no_arvalid", 64'(m_axi_arvalid), 64'(0));
      chk("hold_not_busy", 64'(busy), 64'(0));
    end
    @(negedge clk); hold = 1'b0; #1;
    chk("hold_release_cycle", 64'(m_axi_arvalid), 64'(0));
    run_txn(0, 0, 8'hFF, 1, 0);

    // Back-to-back s0 grants drive the counter into saturation.
    do_reset();
    for (int i = 0; i < 36; i++) begin
      set_req(0, 34'(i * 64), 8'd0, 3'(i));
      run_txn(0, 0, 8'hFF, (i + 1 > 31) ? 31 : i + 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
